fcvt_rr_sched: RTL

- Round-robin scheduler that shares one combinational integer-to-double converter, FCVT_fp (ports in[63:0] and fp[63:0]), between two requesters.
- Requesters are typically the integer pipeline and the FP issue queue.
- Registers the operand, registers the converted result, and returns it with the requester ID and tag over a valid/ready response channel.
- Sits between issue and FP writeback in the FPU.

---
 rtl/fcvt_rr_sched.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/fcvt_rr_sched.sv
// fcvt_rr_sched: round-robin arbiter that shares one integer-to-double
// converter (fcvt_fp) between two requesters.
//
// Operation:
// - The accepted operand is registered, converted during CONV, and the
//   result is held in DONE on a valid/ready response channel.
// - In DONE, when the consumer accepts the result (resp_ready high), a new
//   request can be taken in the same cycle.
//
// Optional build macro FCVT_RR_SCHED_PERF_EN adds per-requester counters of
// completed responses.
module fcvt_rr_sched #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [63:0]      req0_data,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [63:0]      req1_data,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [63:0]      resp_fp,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag
`ifdef FCVT_RR_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_cnt0,
    output logic [31:0]      perf_cnt1
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Signed 64-bit integer to IEEE-754 double, round-to-nearest-even.
    function automatic logic [63:0] fcvt_fp(input logic [63:0] in);
        logic        sign_v;
        logic [63:0] abs_v;
        logic [5:0]  msb_v;
        logic [62:0] norm_v;
        logic [10:0] exp_v;
        logic        round_up_v;
        logic [63:0] fp_v;
        sign_v = in[63];
        if (sign_v) begin
            abs_v = ~in + 64'd1;
        end else begin
            abs_v = in;
        end
        msb_v = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (abs_v[i]) begin
                msb_v = i[5:0];
            end else begin
                msb_v = msb_v;
            end
        end
        // Leading one shifted out of bit 63; the rest is mantissa, guard and sticky.
        norm_v     = 63'(abs_v << (6'd63 - msb_v));
        exp_v      = 11'd1023 + {5'd0, msb_v};
        round_up_v = norm_v[10] & ((|norm_v[9:0]) | norm_v[11]);
        if (abs_v == 64'd0) begin
            fp_v = 64'd0;
        end else begin
            // A mantissa carry from rounding ripples into the exponent field.
            fp_v = {sign_v, ({exp_v, norm_v[62:11]} + {62'd0, round_up_v})};
        end
        return fp_v;
    endfunction

    logic [1:0]         state_r;
    logic [1:0]         next_state_s;
    logic               rr_ptr_r;
    logic               grant_id_s;
    logic               slot_open_s;
    logic               hs_s;
    logic [63:0]        op_r;
    logic               meta_id_r;
    logic [TAG_W-1:0]   meta_tag_r;
    logic [63:0]        fcvt_out_s;
    logic               resp_valid_r;
    logic [63:0]        resp_fp_r;
    logic               resp_id_r;
    logic [TAG_W-1:0]   resp_tag_r;

    // Grant selection and handshake: a lone valid requester wins; on a tie rr_ptr decides.
    always_comb begin
        if (req0_valid && !req1_valid) begin
            grant_id_s = 1'b0;
        end else if (!req0_valid && req1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = rr_ptr_r;
        end
        slot_open_s = (state_r == IDLE) || ((state_r == DONE) && resp_ready);
        hs_s        = slot_open_s && (req0_valid || req1_valid) && !rst;
        req0_ready  = hs_s && !grant_id_s;
        req1_ready  = hs_s && grant_id_s;
    end

    // Next-state logic for the IDLE/CONV/DONE sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (hs_s) begin
                    next_state_s = CONV;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CONV: next_state_s = DONE;
            DONE: begin
                if (resp_ready) begin
                    if (hs_s) begin
                        next_state_s = CONV;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Single shared converter instance, fed from the operand register.
    always_comb begin
        fcvt_out_s = fcvt_fp(op_r);
    end

    // State register; resp_valid is registered alongside so it mirrors DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            resp_valid_r <= (next_state_s == DONE);
        end
    end

    // Capture operand and metadata on a handshake and rotate priority away from the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r       <= 64'd0;
            meta_id_r  <= 1'b0;
            meta_tag_r <= '0;
            rr_ptr_r   <= 1'b0;
        end else if (hs_s) begin
            op_r       <= grant_id_s ? req1_data : req0_data;
            meta_id_r  <= grant_id_s;
            meta_tag_r <= grant_id_s ? req1_tag : req0_tag;
            rr_ptr_r   <= ~grant_id_s;
        end else begin
            op_r       <= op_r;
            meta_id_r  <= meta_id_r;
            meta_tag_r <= meta_tag_r;
            rr_ptr_r   <= rr_ptr_r;
        end
    end

    // Load the response registers in CONV; they hold through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_fp_r  <= 64'd0;
            resp_id_r  <= 1'b0;
            resp_tag_r <= '0;
        end else if (state_r == CONV) begin
            resp_fp_r  <= fcvt_out_s;
            resp_id_r  <= meta_id_r;
            resp_tag_r <= meta_tag_r;
        end else begin
            resp_fp_r  <= resp_fp_r;
            resp_id_r  <= resp_id_r;
            resp_tag_r <= resp_tag_r;
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_fp    = resp_fp_r;
    assign resp_id    = resp_id_r;
    assign resp_tag   = resp_tag_r;

`ifdef FCVT_RR_SCHED_PERF_EN
    logic [31:0] perf_cnt0_r;
    logic [31:0] perf_cnt1_r;

    // Count completed responses per requester; counters wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt0_r <= 32'd0;
            perf_cnt1_r <= 32'd0;
        end else if (resp_valid_r && resp_ready) begin
            if (resp_id_r) begin
                perf_cnt1_r <= perf_cnt1_r + 32'd1;
            end else begin
                perf_cnt0_r <= perf_cnt0_r + 32'd1;
            end
        end else begin
            perf_cnt0_r <= perf_cnt0_r;
            perf_cnt1_r <= perf_cnt1_r;
        end
    end

    assign perf_cnt0 = perf_cnt0_r;
    assign perf_cnt1 = perf_cnt1_r;
`endif

endmodule
